sel_scan_seq: RTL and testbench

// - Upstream select sequencer for the 3-to-8 one-hot decoder: walks channels
//   0..7 and drives {sel1,sel2,sel3} (sel1 = MSB) to the decoder inputs.
// - Skips masked-off channels and holds each enabled channel for a

---
 rtl/sel_scan_seq_if.sv | 41 ++++
 rtl/sel_scan_seq.sv | 178 +++++++++++++++++
 tb/tb_sel_scan_seq.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sel_scan_seq_if.sv
// rtl/sel_scan_seq_if.sv - request/select bundle between scan controller and sel_scan_seq
// Purpose: groups the scan request inputs and the select/status outputs.
// Optional macro: SCAN_REVERSE_DIR_EN adds the dir signal.
// Signals:
//   start, stop, mode, ch_mask[7:0], dwell[DWELL_W-1:0], dir  : controller -> sequencer
//   sel1, sel2, sel3, valid, busy, done                       : sequencer -> controller/decoder
// Modports: master = scan controller, slave = sequencer.
interface sel_scan_seq_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               mode;
  logic [7:0]         ch_mask;
  logic [DWELL_W-1:0] dwell;
`ifdef SCAN_REVERSE_DIR_EN
  logic               dir;
`endif
  logic               sel1;
  logic               sel2;
  logic               sel3;
  logic               valid;
  logic               busy;
  logic               done;

  modport master (
`ifdef SCAN_REVERSE_DIR_EN
    output dir,
`endif
    output start, stop, mode, ch_mask, dwell,
    input  sel1, sel2, sel3, valid, busy, done
  );

  modport slave (
`ifdef SCAN_REVERSE_DIR_EN
    input  dir,
`endif
    input  start, stop, mode, ch_mask, dwell,
    output sel1, sel2, sel3, valid, busy, done
  );
endinterface

// File: rtl/sel_scan_seq.sv
// rtl/sel_scan_seq.sv - channel select sequencer feeding a 3-to-8 one-hot decoder
// Purpose: walks the enabled channels of a latched mask, holding each for
//   dwell+1 cycles, as a single sweep or continuously; done pulses at the
//   end of a single sweep or on a start with an empty mask.
// Optional macro: SCAN_REVERSE_DIR_EN enables the dir input (1 = descending scan).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : sel_scan_seq_if.slave (start/stop/mode/ch_mask/dwell[/dir] in,
//          sel1/sel2/sel3/valid/busy/done out, all outputs registered)
module sel_scan_seq #(
  parameter int DWELL_W = 8
) (
  input  logic           clk,
  input  logic           rst,
  sel_scan_seq_if.slave  bus
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state_q, state_d;
  logic [2:0]         ch_q, ch_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [7:0]         mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               mode_q, mode_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               start_desc;
  logic               scan_desc;

`ifdef SCAN_REVERSE_DIR_EN
  logic               dir_q, dir_d;
  assign start_desc = bus.dir;
  assign scan_desc  = dir_q;
`else
  assign start_desc = 1'b0;
  assign scan_desc  = 1'b0;
`endif

  // Lowest enabled channel (highest when descending).
  function automatic logic [2:0] first_ch(input logic [7:0] m, input logic desc);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!desc && m[i]) r = 3'(i);
    end
    for (int i = 0; i < 8; i++) begin
      if (desc && m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // {found, index} of the next enabled channel beyond cur in scan direction.
  function automatic logic [3:0] next_ch(input logic [7:0] m, input logic [2:0] cur,
                                         input logic desc);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!desc && m[i] && (i > int'(cur))) r = {1'b1, 3'(i)};
    end
    for (int i = 0; i < 8; i++) begin
      if (desc && m[i] && (i < int'(cur))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  logic [2:0] first_start;
  logic [2:0] first_scan;
  logic [3:0] nxt;

  assign first_start = first_ch(bus.ch_mask, start_desc);
  assign first_scan  = first_ch(mask_q, scan_desc);
  assign nxt         = next_ch(mask_q, ch_q, scan_desc);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    dwell_d = dwell_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SCAN_REVERSE_DIR_EN
    dir_d   = dir_q;
`endif
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        ch_d    = 3'd0;
        if (bus.start && !bus.stop) begin
          if (bus.ch_mask != 8'd0) begin
            state_d = SCAN;
            mask_d  = bus.ch_mask;
            dwell_d = bus.dwell;
            mode_d  = bus.mode;
`ifdef SCAN_REVERSE_DIR_EN
            dir_d   = bus.dir;
`endif
            ch_d    = first_start;
            cnt_d   = bus.dwell;
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SCAN: begin
        if (bus.stop) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          ch_d    = 3'd0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else if (nxt[3]) begin
          ch_d  = nxt[2:0];
          cnt_d = dwell_q;
        end else if (mode_q) begin
          // Continuous: wrap with no gap; a single-channel mask just reloads.
          ch_d  = first_scan;
          cnt_d = dwell_q;
        end else begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          ch_d    = 3'd0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= 3'd0;
      cnt_q   <= '0;
      mask_q  <= 8'd0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SCAN_REVERSE_DIR_EN
      dir_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SCAN_REVERSE_DIR_EN
      dir_q   <= dir_d;
`endif
    end
  end

  assign bus.sel1  = ch_q[2];
  assign bus.sel2  = ch_q[1];
  assign bus.sel3  = ch_q[0];
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_sel_scan_seq.sv
// tb/tb_sel_scan_seq.sv - self-checking bench for sel_scan_seq (optional macro SCAN_REVERSE_DIR_EN)
module tb_sel_scan_seq;

  localparam int DWELL_W = 8;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sel_scan_seq_if #(.DWELL_W(DWELL_W)) ifc ();

  sel_scan_seq #(.DWELL_W(DWELL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  int checks = 0;
  int errors = 0;

  // Expected per-cycle output word: {valid, busy, done, sel[2:0]}.
  logic [5:0] exp_q[$];

  function automatic logic [5:0] observed();
    return {ifc.valid, ifc.busy, ifc.done, ifc.sel1, ifc.sel2, ifc.sel3};
  endfunction

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed={v,b,d,sel}=%b expected=%b", tag, obs, expv);
    end
  endtask

  // Reference: list the enabled channels in scan order, repeat each dwell+1
  // times; single sweep ends with a done cycle and an idle cycle, continuous
  // keeps cycling the list for ncont cycles.
  function automatic void build(input logic [7:0] m, input int dw, input bit md,
                                input bit dr, input int ncont);
    int chs[$];
    exp_q.delete();
    if (m == 8'd0) begin
      exp_q.push_back(6'b001_000);
      exp_q.push_back(6'b000_000);
      return;
    end
    for (int i = 0; i < 8; i++) begin
      int c;
      c = dr ? 7 - i : i;
      if (m[c]) chs.push_back(c);
    end
    if (!md) begin
      foreach (chs[k])
        for (int r = 0; r <= dw; r++) exp_q.push_back({3'b110, 3'(chs[k])});
      exp_q.push_back(6'b001_000);
      exp_q.push_back(6'b000_000);
    end else begin
      int k;
      k = 0;
      while (exp_q.size() < ncont) begin
        for (int r = 0; r <= dw && exp_q.size() < ncont; r++)
          exp_q.push_back({3'b110, 3'(chs[k])});
        k = (k + 1) % chs.size();
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a scan and checks every following cycle against the model.
  // inject: pulse start (with garbage settings) while busy.
  // rst_at: assert rst after checking that entry (-1 = never).
  task automatic run_scan(input string tag, input logic [7:0] m, input int dw,
                          input bit md, input bit dr, input int ncont,
                          input bit inject, input int rst_at);
    build(m, dw, md, dr, ncont);
    ifc.ch_mask = m;
    ifc.dwell   = DWELL_W'(dw);
    ifc.mode    = md;
`ifdef SCAN_REVERSE_DIR_EN
    ifc.dir     = dr;
`endif
    ifc.start   = 1'b1;
    tick();
    ifc.start   = 1'b0;
    // Scrambled inputs mid-scan must not matter: settings are latched.
    ifc.ch_mask = 8'($urandom);
    ifc.dwell   = DWELL_W'($urandom);
    ifc.mode    = 1'($urandom);
    foreach (exp_q[i]) begin
      chk($sformatf("%s[%0d]", tag, i), observed(), exp_q[i]);
      if (i == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk({tag, "_rst"}, observed(), 6'b000_000);
        tick();
        chk({tag, "_rst2"}, observed(), 6'b000_000);
        return;
      end
      ifc.start = inject && exp_q[i][4];
      tick();
    end
    ifc.start = 1'b0;
    if (md && m != 8'd0) begin
      ifc.stop = 1'b1;
      tick();
      ifc.stop = 1'b0;
      chk({tag, "_stop"}, observed(), 6'b000_000);
      tick();
      chk({tag, "_stop2"}, observed(), 6'b000_000);
    end
  endtask

  initial begin
    rst         = 1'b1;
    ifc.start   = 1'b0;
    ifc.stop    = 1'b0;
    ifc.mode    = 1'b0;
    ifc.ch_mask = 8'd0;
    ifc.dwell   = '0;
`ifdef SCAN_REVERSE_DIR_EN
    ifc.dir     = 1'b0;
`endif
    tick();
    tick();
    chk("reset", observed(), 6'b000_000);
    rst = 1'b0;
    tick();
    chk("idle", observed(), 6'b000_000);

    run_scan("T1", 8'hFF, 0, 1'b0, 1'b0, 0, 1'b0, -1);
    run_scan("T2", 8'b1010_0100, 2, 1'b0, 1'b0, 0, 1'b0, -1);
    run_scan("T3", 8'h81, 1, 1'b1, 1'b0, 12, 1'b0, -1);
    run_scan("T3one", 8'h10, 2, 1'b1, 1'b0, 10, 1'b0, -1);
    run_scan("T4empty", 8'h00, 3, 1'b0, 1'b0, 0, 1'b0, -1);

    // start and stop together in IDLE: nothing at all.
    ifc.ch_mask = 8'hFF;
    ifc.start   = 1'b1;
    ifc.stop    = 1'b1;
    tick();
    ifc.start   = 1'b0;
    ifc.stop    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("T4startstop[%0d]", i), observed(), 6'b000_000);
      tick();
    end

    run_scan("T4inject", 8'b0110_1001, 1, 1'b0, 1'b0, 0, 1'b1, -1);
    run_scan("T5rst", 8'b1010_0100, 2, 1'b0, 1'b0, 0, 1'b0, 3);
    run_scan("T5again", 8'b1010_0100, 2, 1'b0, 1'b0, 0, 1'b0, -1);

`ifdef SCAN_REVERSE_DIR_EN
    run_scan("T6", 8'hFF, 0, 1'b0, 1'b1, 0, 1'b0, -1);
    run_scan("T6cont", 8'b1001_0010, 1, 1'b1, 1'b1, 15, 1'b0, -1);
    run_scan("T6fwd", 8'hFF, 0, 1'b0, 1'b0, 0, 1'b0, -1);
`endif

    for (int n = 0; n < 20; n++) begin
      logic [7:0] m;
      int dw;
      bit md;
      bit dr;
      m  = 8'($urandom);
      dw = $urandom_range(0, 3);
      md = 1'($urandom);
`ifdef SCAN_REVERSE_DIR_EN
      dr = 1'($urandom);
`else
      dr = 1'b0;
`endif
      run_scan($sformatf("rnd%0d", n), m, dw, md, dr, $urandom_range(5, 30),
               1'($urandom), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
